cmos_crc8_serial: RTL and testbench

Bit-serial CRC-8 generator that consumes the single-bit stream at the output of the transistor-level XOR cells and compresses each fixed-length frame into an 8-bit check value. The feedback XORs are instances of the team's switch-level `cmos_xor` cell, one per set bit of POLY. The register, bit counter and frame FSM are behavioural. The block sits directly downstream of the XOR datapath and hands its result to the frame checker.

---
 rtl/cmos_crc8_serial.sv | 120 ++++++++++++
 tb/tb_cmos_crc8_serial.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cmos_crc8_serial.sv
// Bit-serial CRC-8 over fixed-length frames, MSB first.
// Feedback XORs are cmos_xor cell instances; register/FSM behavioural.

module cmos_xor (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    // Behavioural stand-in for the transistor-level XOR cell.
    assign y_o = a_i ^ b_i;
endmodule

module cmos_crc8_serial #(
    parameter logic [7:0] POLY    = 8'h07,
    parameter logic [7:0] INIT    = 8'h00,
    parameter int         MSG_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       din_valid,
    input  logic       din,
    output logic       ready,
    output logic       busy,
    output logic       crc_valid,
    output logic [7:0] crc_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] crc_q, crc_d;
    logic [7:0] cnt_q, cnt_d;

    logic       fb;
    logic [7:0] crc_shl;
    logic [7:0] crc_nxt;

    cmos_xor u_fb (
        .a_i (crc_q[7]),
        .b_i (din),
        .y_o (fb)
    );

    assign crc_shl = {crc_q[6:0], 1'b0};

    // One XOR cell per tapped bit; untapped bits pass the shift through.
    for (genvar i = 0; i < 8; i++) begin : g_tap
        if (POLY[i]) begin : g_xor
            cmos_xor u_tap (
                .a_i (crc_shl[i]),
                .b_i (fb),
                .y_o (crc_nxt[i])
            );
        end else begin : g_pass
            assign crc_nxt[i] = crc_shl[i];
        end
    end

    // State, CRC and bit-count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode for the frame FSM.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        ready     = 1'b0;
        busy      = 1'b0;
        crc_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    crc_d   = INIT;
                    cnt_d   = 8'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (din_valid) begin
                    crc_d = crc_nxt;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                crc_valid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign crc_out = crc_q;

endmodule

// File: tb/tb_cmos_crc8_serial.sv
// Self-checking bench for cmos_crc8_serial: vector table,
// corner-case sequences and random frames against a division model.

module tb_cmos_crc8_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       din_valid;
    logic       din;
    logic       ready;
    logic       busy;
    logic       crc_valid;
    logic [7:0] crc_out;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;
    int vexp  = 0;

    typedef struct {
        logic [15:0] frame;
        int          gap;
        bit          spam;
        logic [7:0]  exp;
    } vec_t;

    cmos_crc8_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .din_valid (din_valid),
        .din       (din),
        .ready     (ready),
        .busy      (busy),
        .crc_valid (crc_valid),
        .crc_out   (crc_out)
    );

    always #5 clk = ~clk;

    // Count every crc_valid pulse seen at a clock edge.
    always @(posedge clk) begin
        if (crc_valid) vcnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // CRC as remainder of (M(x) * x^8) mod (x^8 + POLY), INIT folded in.
    function automatic logic [7:0] ref_crc(input logic [15:0] m);
        logic [23:0] r;
        logic [23:0] p;
        r = {m, 8'h00} ^ {8'h00, 16'h0000};
        p = 24'h000107;
        for (int b = 23; b >= 8; b--) begin
            if (r[b]) r = r ^ (p << (b - 8));
        end
        return r[7:0];
    endfunction

    // gap: 0 none, 1 every other cycle, 2 random.
    task automatic run_frame(input logic [15:0] f, input int gap,
                             input bit spam, input logic [7:0] exp);
        logic [7:0] prev;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ready_after_start", ready, 1);
        chk("busy_after_start", busy, 1);
        for (int i = 15; i >= 0; i--) begin
            if (gap == 1 || (gap == 2 && ($urandom % 3) == 0)) begin
                din_valid = 1'b0;
                din = 1'($urandom);
                if (spam) start = 1'b1;
                prev = crc_out;
                tick();
                chk("gap_hold", crc_out, prev);
                chk("gap_ready", ready, 1);
            end
            din_valid = 1'b1;
            din = f[i];
            if (spam) start = 1'($urandom);
            tick();
            if (i > 0) chk("no_early_valid", crc_valid, 0);
        end
        din_valid = 1'b1;
        din = 1'($urandom);
        start = spam;
        chk("done_valid", crc_valid, 1);
        chk("done_busy", busy, 1);
        chk("done_ready", ready, 0);
        chk("done_crc", crc_out, exp);
        vexp++;
        tick();
        start = 1'b0;
        din_valid = 1'b0;
        chk("idle_valid", crc_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", ready, 0);
        chk("idle_crc_hold", crc_out, exp);
    endtask

    initial begin
        vec_t vt[5];
        logic [15:0] rf;

        vt[0] = '{16'h0100, 0, 1'b0, 8'h15};
        vt[1] = '{16'h0001, 1, 1'b0, 8'h07};
        vt[2] = '{16'h0000, 0, 1'b0, 8'h00};
        vt[3] = '{16'h0100, 0, 1'b0, 8'h15};
        vt[4] = '{16'h0100, 1, 1'b1, 8'h15};

        rst_n = 1'b0;
        start = 1'b1;
        din_valid = 1'b1;
        din = 1'b1;
        tick();
        tick();
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", crc_valid, 0);
        chk("rst_crc", crc_out, 8'h00);
        rst_n = 1'b1;
        start = 1'b0;
        din_valid = 1'b0;
        tick();
        chk("idle_no_start", busy, 0);

        // Frames 2 and 3 are back to back: start in cycle after crc_valid.
        for (int k = 0; k < 5; k++) begin
            run_frame(vt[k].frame, vt[k].gap, vt[k].spam, vt[k].exp);
        end

        // Abort after 9 bits of 0x0100, reset dominates start/din_valid.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        rf = 16'h0100;
        for (int i = 15; i >= 7; i--) begin
            din_valid = 1'b1;
            din = rf[i];
            tick();
        end
        rst_n = 1'b0;
        start = 1'b1;
        din_valid = 1'b1;
        tick();
        chk("abort_valid", crc_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_crc", crc_out, 8'h00);
        rst_n = 1'b1;
        start = 1'b0;
        din_valid = 1'b0;
        tick();
        chk("abort_idle", busy, 0);
        run_frame(16'h0001, 0, 1'b0, 8'h07);

        // Random frames with random gaps against the division model.
        for (int k = 0; k < 20; k++) begin
            rf = 16'($urandom);
            run_frame(rf, 2, 1'($urandom), ref_crc(rf));
        end

        tick();
        chk("valid_pulse_count", vcnt, vexp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
